// File: rtl/pov_column_seq.sv
// pov_column_seq
//   Column sequencer for the POV LED fan. It synchronises the hall-sensor
//   once-per-revolution mark and measures the revolution period in clk
//   cycles. It splits that period into 2^COL_LOG2 angular columns, steps a
//   column index in real time, and presents the matching 16-bit pattern word
//   from a writable pattern RAM to the dimmer stage. The output is blanked
//   until the fan is synced, and again whenever it stalls.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-low
//   hall_in    raw asynchronous hall input; a rising edge marks a revolution
//   wr_en      pattern RAM write strobe (accepted in any state)
//   wr_addr    pattern RAM column address
//   wr_data    pattern word for that column
//   faceled    registered column pattern to the dim stage
//   col_idx    current column index
//   rev_pulse  one-cycle pulse per accepted revolution edge
//   stalled    high while the fan is considered stalled
module pov_column_seq #(
  parameter int unsigned COL_LOG2   = 6,
  parameter int unsigned PER_W      = 27,
  parameter int unsigned MIN_PERIOD = 100000,
  parameter int unsigned TIMEOUT    = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hall_in,
  input  logic                wr_en,
  input  logic [COL_LOG2-1:0] wr_addr,
  input  logic [15:0]         wr_data,
  output logic [15:0]         faceled,
  output logic [COL_LOG2-1:0] col_idx,
  output logic                rev_pulse,
  output logic                stalled
);

  localparam int unsigned       NCOL      = 1 << COL_LOG2;
  localparam logic [PER_W-1:0]  MIN_P     = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]  TIMEOUT_P = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0]  ONE_P     = PER_W'(1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    MEASURE,
    RUN,
    STALL
  } state_t;

  state_t state;
  state_t next_state;

  logic s1, s2, s3;
  logic hall_edge;
  logic accept;
  logic timed_out;

  logic [PER_W-1:0] period_cnt;
  logic [PER_W-1:0] last_period;
  logic [PER_W-1:0] col_cnt;
  logic [PER_W-1:0] col_len_raw;
  logic [PER_W-1:0] col_len;
  logic             col_end;

  logic [15:0] ram [NCOL];

  // Hall synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= hall_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign hall_edge = s2 & ~s3;

  // The debounce window applies only while timing a revolution. A first
  // edge, or an edge that recovers from a stall, is always taken.
  assign accept = hall_edge &&
                  ((state == WAIT_SYNC) || (state == STALL) || (period_cnt >= MIN_P));

  assign timed_out = (period_cnt == TIMEOUT_P);

  assign col_len_raw = last_period >> COL_LOG2;
  assign col_len     = (col_len_raw == '0) ? ONE_P : col_len_raw;
  assign col_end     = (col_cnt == col_len - ONE_P);

  assign stalled = (state == STALL);

  always_comb begin
    next_state = state;
    case (state)
      WAIT_SYNC: if (accept) next_state = MEASURE;
      MEASURE: begin
        if (accept)         next_state = RUN;
        else if (timed_out) next_state = STALL;
      end
      RUN: begin
        if (accept)         next_state = RUN;
        else if (timed_out) next_state = STALL;
      end
      STALL:     if (accept) next_state = MEASURE;
      default:   next_state = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= WAIT_SYNC;
    else      state <= next_state;
  end

  // Revolution timing. The captured period also counts the accept cycle, so
  // last_period equals the spacing between hall edges in clk cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      period_cnt  <= '0;
      last_period <= '0;
      rev_pulse   <= 1'b0;
    end else begin
      rev_pulse <= accept;
      if (accept) begin
        period_cnt <= '0;
        if ((state == MEASURE) || (state == RUN))
          last_period <= period_cnt + ONE_P;
      end else if (!timed_out) begin
        period_cnt <= period_cnt + ONE_P;
      end
    end
  end

  // Column stepping. The index saturates on the last column and holds there
  // until the next revolution edge. It is forced to 0 whenever the next state
  // is not RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt <= '0;
      col_idx <= '0;
    end else if (accept || (next_state != RUN)) begin
      col_cnt <= '0;
      col_idx <= '0;
    end else if (col_end) begin
      col_cnt <= '0;
      if (col_idx != '1)
        col_idx <= col_idx + COL_LOG2'(1);
    end else begin
      col_cnt <= col_cnt + ONE_P;
    end
  end

  // Pattern RAM. A write lands at the same edge that reads for faceled, so a
  // word written to the displayed column appears one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCOL; i++)
        ram[i] <= '0;
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // The display is live only while RUN is both the current and the next
  // state. This blanks the output on the same cycle that a stall is entered,
  // and keeps it blank on the cycle that first enters RUN from MEASURE.
  always_ff @(posedge clk) begin
    if (!rst)
      faceled <= '0;
    else if ((state == RUN) && (next_state == RUN))
      faceled <= ram[col_idx];
    else
      faceled <= '0;
  end

endmodule
